// File: rtl/pipe_mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory op codes,
// FSM state encoding and small op-classification helpers.
package pipe_mem_stage_pkg;

  localparam logic RST_ENABLED   = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;

  localparam logic [3:0] DMEM_NONE = 4'd0;
  localparam logic [3:0] DMEM_LB   = 4'd1;
  localparam logic [3:0] DMEM_LBU  = 4'd2;
  localparam logic [3:0] DMEM_LH   = 4'd3;
  localparam logic [3:0] DMEM_LHU  = 4'd4;
  localparam logic [3:0] DMEM_LW   = 4'd5;
  localparam logic [3:0] DMEM_SB   = 4'd6;
  localparam logic [3:0] DMEM_SH   = 4'd7;
  localparam logic [3:0] DMEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 9..15 fall outside both ranges and behave like DMEM_NONE.
  function automatic logic f_op_valid(input logic [3:0] op);
    return (op >= DMEM_LB) && (op <= DMEM_SW);
  endfunction

  function automatic logic f_is_load(input logic [3:0] op);
    return (op >= DMEM_LB) && (op <= DMEM_LW);
  endfunction

  function automatic logic f_is_store(input logic [3:0] op);
    return (op >= DMEM_SB) && (op <= DMEM_SW);
  endfunction

  function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = (op == DMEM_LH) || (op == DMEM_LHU) || (op == DMEM_SH);
    word_op = (op == DMEM_LW) || (op == DMEM_SW);
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/pipe_mem_lsu_align.sv
// Lane steering for the load/store unit: byte enables, replicated store data
// and sign/zero-extended load data from op and the low address bits.
module pipe_mem_lsu_align
  import pipe_mem_stage_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // Halfword lane comes from addr[1] only; addr[0] never moves the lane.
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_rt;
    case (i_op)
      DMEM_SB: begin
        o_be    = 4'b0001 << i_lo;
        o_wdata = {4{i_rt[7:0]}};
      end
      DMEM_SH: begin
        o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_rt[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_op)
      DMEM_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      DMEM_LBU: o_load = {24'd0, w_byte};
      DMEM_LH:  o_load = {{16{w_half[15]}}, w_half};
      DMEM_LHU: o_load = {16'd0, w_half};
      default:  o_load = i_rdata;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM-stage load/store unit: runs one req/ack data-bus transaction per op and
// stalls the pipeline while it is in flight. Optional: MEM_ALIGN_CHECK_EN.
module pipe_mem_stage
  import pipe_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_alu_out,
  input  logic [31:0]       mem_rt_data,
  input  logic [3:0]        mem_dmem_op,
  input  logic              mem_flush,
  output logic [31:0]       mem_dmem_out,
  output logic              stall_req,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic              mem_addr_err
);

  state_t      r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_lo;
  logic        r_err;

  logic        w_is_idle;
  logic        w_start;
  logic        w_misalign;
  logic [3:0]  w_op_sel;
  logic [1:0]  w_lo_sel;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_is_idle = (r_state == ST_IDLE);
  assign w_start   = f_op_valid(mem_dmem_op) && !mem_flush;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = f_misaligned(mem_dmem_op, mem_alu_out[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Live inputs steer the store lanes at issue; latched op/lane steer the load.
  assign w_op_sel = w_is_idle ? mem_dmem_op       : r_op;
  assign w_lo_sel = w_is_idle ? mem_alu_out[1:0]  : r_lo;

  pipe_mem_lsu_align u_align (
    .i_op    (w_op_sel),
    .i_lo    (w_lo_sel),
    .i_rt    (mem_rt_data),
    .i_rdata (dbus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_load  (w_load)
  );

  assign stall_req    = (rst != RST_ENABLED) &&
                        ((w_is_idle && w_start) || (r_state == ST_REQ));
  assign mem_addr_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      r_state      <= ST_IDLE;
      r_op         <= DMEM_NONE;
      r_lo         <= 2'b00;
      r_err        <= 1'b0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= '0;
      dbus_be      <= 4'b0000;
      dbus_wdata   <= 32'd0;
      mem_dmem_out <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_op       <= mem_dmem_op;
              r_lo       <= mem_alu_out[1:0];
              dbus_req   <= 1'b1;
              dbus_we    <= f_is_store(mem_dmem_op) ? WRITE_ENABLED : ~WRITE_ENABLED;
              dbus_addr  <= {mem_alu_out[ADDR_W-1:2], 2'b00};
              dbus_be    <= w_be;
              dbus_wdata <= w_wdata;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (f_is_load(r_op)) begin
              mem_dmem_out <= w_load;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized bench for pipe_mem_stage against a transaction-level model of the
// load/store unit, plus literal pins for the directed cases.
`timescale 1ns/1ps
module tb_pipe_mem_stage;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_alu_out = 32'd0;
  logic [31:0] mem_rt_data = 32'd0;
  logic [3:0]  mem_dmem_op = 4'd0;
  logic        mem_flush = 1'b0;
  logic [31:0] mem_dmem_out;
  logic        stall_req;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = 32'd0;
  logic        mem_addr_err;

  always #5 clk = ~clk;

  pipe_mem_stage #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_alu_out  (mem_alu_out),
    .mem_rt_data  (mem_rt_data),
    .mem_dmem_op  (mem_dmem_op),
    .mem_flush    (mem_flush),
    .mem_dmem_out (mem_dmem_out),
    .stall_req    (stall_req),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata),
    .mem_addr_err (mem_addr_err)
  );

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  int err_cnt = 0;

  // Model: what the bus/result outputs must show this cycle.
  logic [31:0] m_out = 32'd0, m_addr = 32'd0, m_wdata = 32'd0;
  logic [3:0]  m_be = 4'd0;
  logic        m_we = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_err = 1'b0;
  bit          e_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_valid(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd8;
  endfunction
  function automatic bit is_load(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction
  function automatic bit is_store(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (addr % 2 != 0)) return 1'b1;
    if ((op == OP_LW || op == OP_SW) && (addr % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
    if (op == OP_SB) return 4'(32'd1 << (addr % 4));
    if (op == OP_SH) return (addr % 4 >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] rt);
    if (op == OP_SB) return (rt & 32'hFF) * 32'h01010101;
    if (op == OP_SH) return (rt & 32'hFFFF) * 32'h00010001;
    return rt;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> ((addr % 4) * 8)) & 32'hFF;
    h = (rd >> ((addr % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (stall_req === 1'b1) stall_cnt++;
    if (mem_addr_err === 1'b1) err_cnt++;
    if (e_valid) begin
      chk("stall_req",    stall_req,    e_stall);
      chk("dbus_req",     dbus_req,     e_req);
      chk("dbus_we",      dbus_we,      m_we);
      chk("dbus_addr",    dbus_addr,    m_addr);
      chk("dbus_be",      dbus_be,      m_be);
      chk("dbus_wdata",   dbus_wdata,   m_wdata);
      chk("mem_dmem_out", mem_dmem_out, m_out);
      chk("mem_addr_err", mem_addr_err, e_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One op from detect through DONE (or a single idle cycle if nothing starts).
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rd, input int dly, input bit flush);
    bit start;
    start = is_valid(op) && !flush;
    step();
    mem_dmem_op = op; mem_alu_out = addr; mem_rt_data = rt; mem_flush = flush;
    dbus_ack = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
    e_stall = start; e_req = 1'b0; e_err = 1'b0;
    if (start && misaligned(op, addr)) begin
      step();
      mem_flush = 1'($urandom_range(0, 1)); dbus_ack = 1'($urandom_range(0, 1));
      e_stall = 1'b0; e_err = 1'b1;
    end else if (start) begin
      for (int k = 0; k <= dly; k++) begin
        step();
        if (k == 0) begin
          m_addr = {addr[31:2], 2'b00}; m_be = exp_be(op, addr);
          m_we = is_store(op); m_wdata = exp_wdata(op, rt);
        end
        mem_flush = 1'($urandom_range(0, 1));
        dbus_ack = (k == dly);
        dbus_rdata = (k == dly) ? rd : $urandom;
        e_stall = 1'b1; e_req = 1'b1;
      end
      step();
      if (is_load(op)) m_out = exp_load(op, addr, rd);
      mem_flush = 1'($urandom_range(0, 1)); dbus_ack = 1'($urandom_range(0, 1));
      dbus_rdata = $urandom;
      e_stall = 1'b0; e_req = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int s0, e0;
    logic [31:0] a;
    #3;
    chk("rst_req", dbus_req, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_out", mem_dmem_out, 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_err", mem_addr_err, 1'b0);
    step(); step();
    rst = 1'b0;
    e_valid = 1'b1;

    s0 = stall_cnt;
    run_op(OP_LW, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0);
    chk("t1_out", mem_dmem_out, 32'hDEADBEEF);
    chk("t1_be", dbus_be, 4'hF);
    chk("t1_stalls", stall_cnt - s0, 2);

    run_op(OP_LB, 32'h103, 32'd0, 32'h80123456, 0, 1'b0);
    chk("t2_lb", mem_dmem_out, 32'hFFFFFF80);
    run_op(OP_LBU, 32'h103, 32'd0, 32'h80123456, 1, 1'b0);
    chk("t2_lbu", mem_dmem_out, 32'h00000080);

    run_op(OP_SH, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b0);
    chk("t3_we", dbus_we, 1'b1);
    chk("t3_be", dbus_be, 4'b1100);
    chk("t3_wdata", dbus_wdata, 32'hABCDABCD);
    chk("t3_addr", dbus_addr, 32'h200);
    chk("t3_out", mem_dmem_out, 32'h00000080);

    s0 = stall_cnt;
    run_op(OP_LW, 32'h340, 32'd0, 32'h01234567, 5, 1'b0);
    chk("t4_stalls", stall_cnt - s0, 7);
    chk("t4_out", mem_dmem_out, 32'h01234567);

    s0 = stall_cnt;
    run_op(OP_SW, 32'h400, 32'h55AA55AA, 32'd0, 0, 1'b1);
    chk("t6_flush_stalls", stall_cnt - s0, 0);

`ifdef MEM_ALIGN_CHECK_EN
    s0 = stall_cnt; e0 = err_cnt;
    run_op(OP_LW, 32'h101, 32'd0, 32'hCAFEF00D, 0, 1'b0);
    chk("t6_mis_stalls", stall_cnt - s0, 1);
    chk("t6_mis_err", err_cnt - e0, 1);
    chk("t6_mis_out", mem_dmem_out, 32'h01234567);
`endif

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a request.
    step();
    mem_dmem_op = OP_LW; mem_alu_out = 32'h300; mem_flush = 1'b0; dbus_ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0; e_err = 1'b0;
    step();
    e_valid = 1'b0;
    chk("t5_req_before", dbus_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req_async", dbus_req, 1'b0);
    chk("t5_stall_async", stall_req, 1'b0);
    chk("t5_addr_async", dbus_addr, 32'd0);
    mem_dmem_op = OP_NONE; dbus_ack = 1'b1; dbus_rdata = 32'h11111111;
    step(); step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t5_stray_req", dbus_req, 1'b0);
    chk("t5_stray_stall", stall_req, 1'b0);
    chk("t5_stray_out", mem_dmem_out, 32'd0);
    step();
    dbus_ack = 1'b0;
    m_out = 32'd0; m_addr = 32'd0; m_be = 4'd0; m_we = 1'b0; m_wdata = 32'd0;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
    e_valid = 1'b1;

    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom_range(1, 8)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
             int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
MEM-stage load/store unit, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM address (ALU result), store data and memory op, and runs a request/acknowledge transaction on the data bus. While the access is in flight it stalls the pipeline. It delivers the sign- or zero-extended load result on mem_dmem_out, which feeds the MEM/WB register's mem_dmem_out input.

Parameters:
ADDR_W, 32, data-bus address width; dbus_addr = {mem_alu_out[ADDR_W-1:2], 2'b00}

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
mem_alu_out  input  32  effective address from EX/MEM
mem_rt_data  input  32  store data from EX/MEM
mem_dmem_op  input  4  memory op code (shared constants)
mem_flush  input  1  suppresses start of a new access
mem_dmem_out  output  32  extended load data to MEM/WB
stall_req  output  1  high = hold PC/IF/ID/EX/MEM and drive MEM/WB wena low
dbus_req  output  1  bus request, registered
dbus_we  output  1  1 = store
dbus_addr  output  ADDR_W  word-aligned address
dbus_be  output  4  byte enables
dbus_wdata  output  32  lane-replicated store data
dbus_ack  input  1  bus completion strobe
dbus_rdata  input  32  read data, valid with dbus_ack
mem_addr_err  output  1  misaligned access flag (optional feature only)

Behaviour:
- Reset: state=IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0, mem_dmem_out=0, mem_addr_err=0; stall_req=0.
- States: IDLE, REQ, DONE.
- IDLE, when op!=DMEM_NONE and !mem_flush:
  - stall_req=1 (combinational).
  - Register addr, we, be and wdata onto the bus; dbus_req<=1; go to REQ.
- IDLE, when op==DMEM_NONE or mem_flush: no access; stall_req=0; stay in IDLE.
- REQ:
  - dbus_req, addr, be, we and wdata are held stable; stall_req=1.
  - On dbus_ack=1: dbus_req<=0; for loads, mem_dmem_out<=extended rdata; go to DONE.
  - Wait is unbounded.
- DONE:
  - stall_req=0 so the pipeline and MEM/WB advance; mem_dmem_out holds the result.
  - Always go to IDLE next. The same still-present op is never re-issued.
- Minimum access time: 3 cycles (IDLE-detect, REQ with ack, DONE), of which 2 are stall cycles. Back-to-back ops: the next op is detected in the IDLE cycle after DONE.
- mem_dmem_out is updated only on a load ack; stores leave it unchanged.
- Byte enables:
  - SB: 1<<addr[1:0].
  - SH: 4'b0011<<addr[1:0] (addr[0] must be 0).
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Store data lanes:
  - SB: {4{rt[7:0]}}.
  - SH: {2{rt[15:0]}}.
  - SW: rt.
- Load extension: select the lane by addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- dbus_ack outside REQ is ignored.
- mem_flush after leaving IDLE is ignored; the bus transaction always completes.
- Reset mid-REQ: dbus_req drops asynchronously and the transaction is abandoned. The bus must tolerate this.
- Undefined op codes (9..15) are treated as DMEM_NONE.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined:
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, does not issue a bus request.
  - Instead, the unit goes IDLE->DONE with mem_addr_err=1 for the DONE cycle; stall_req is 1 for the detect cycle only; mem_dmem_out is unchanged.
- Undefined:
  - mem_addr_err is tied to 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

Decomposition:
- Shared define file: DMEM_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; state encodings; plus the existing RST_ENABLED and WRITE_ENABLED.
- One natural combinational sub-module, pipe_mem_lsu_align: op + addr[1:0] + rt/rdata -> be, wdata, extended load data.

Test Plan:
1. LW at 0x100, ack on first REQ cycle, rdata=0xDEADBEEF -> stall_req 1 for 2 cycles; mem_dmem_out=0xDEADBEEF in DONE; dbus_be=4'hF.
2. LB at 0x103, rdata=0x80xxxxxx -> mem_dmem_out=0xFFFFFF80. LBU at the same address -> 0x00000080.
3. SH at 0x202, rt=0x1234ABCD -> dbus_we=1, dbus_be=4'b1100, dbus_wdata=0xABCDABCD, dbus_addr=0x200; mem_dmem_out unchanged.
4. LW with ack delayed 5 cycles -> dbus_req and address stable for all 6 REQ cycles; stall_req 1 for 7 cycles total.
5. Async rst asserted mid-REQ -> dbus_req=0 and stall_req=0 immediately; state IDLE; a stray ack afterwards is ignored.
6. With MEM_ALIGN_CHECK_EN, LW at 0x101 -> no dbus_req; mem_addr_err=1 for one cycle; 1 stall cycle. mem_flush=1 with op=SW -> no request, no stall.
